// File: rtl/disp_pkg.sv
// Shared constants and the hex-to-seven-segment decode used by the display multiplexer.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low.
package disp_pkg;

    localparam logic [6:0] SEG7_0 = 7'b1000000;
    localparam logic [6:0] SEG7_1 = 7'b1111001;
    localparam logic [6:0] SEG7_2 = 7'b0100100;
    localparam logic [6:0] SEG7_3 = 7'b0110000;
    localparam logic [6:0] SEG7_4 = 7'b0011001;
    localparam logic [6:0] SEG7_5 = 7'b0010010;
    localparam logic [6:0] SEG7_6 = 7'b0000010;
    localparam logic [6:0] SEG7_7 = 7'b1111000;
    localparam logic [6:0] SEG7_8 = 7'b0000000;
    localparam logic [6:0] SEG7_9 = 7'b0010000;
    localparam logic [6:0] SEG7_A = 7'b0001000;
    localparam logic [6:0] SEG7_B = 7'b0000011;
    localparam logic [6:0] SEG7_C = 7'b1000110;
    localparam logic [6:0] SEG7_D = 7'b0100001;
    localparam logic [6:0] SEG7_E = 7'b0000110;
    localparam logic [6:0] SEG7_F = 7'b0001110;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    function automatic logic [6:0] seg7_decode(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = SEG7_0;
            4'h1:    seg = SEG7_1;
            4'h2:    seg = SEG7_2;
            4'h3:    seg = SEG7_3;
            4'h4:    seg = SEG7_4;
            4'h5:    seg = SEG7_5;
            4'h6:    seg = SEG7_6;
            4'h7:    seg = SEG7_7;
            4'h8:    seg = SEG7_8;
            4'h9:    seg = SEG7_9;
            4'hA:    seg = SEG7_A;
            4'hB:    seg = SEG7_B;
            4'hC:    seg = SEG7_C;
            4'hD:    seg = SEG7_D;
            4'hE:    seg = SEG7_E;
            default: seg = SEG7_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to active-low seven-segment pattern.
module hex_to_seg7
    import disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    assign seg_n = seg7_decode(hex);

endmodule

// File: rtl/seg7_disp_mux.sv
// Four-digit common-anode display multiplexer with frame-boundary digit capture
// and an anode-off guard interval at the start of every digit slot.
module seg7_disp_mux
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD_CYC   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] dig_0,
    input  logic [3:0] dig_1,
    input  logic [3:0] dig_2,
    input  logic [3:0] dig_3,
    input  logic [3:0] blank,
    input  logic [3:0] dp,
    output logic [3:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic       frame_done
);

    localparam int               CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'(GUARD_CYC);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       sel;
    logic [3:0][3:0]  shadow_dig;
    logic [3:0]       shadow_blank;
    logic [3:0]       shadow_dp;
    logic             load_pend;

    logic             tick;
    logic             load_now;
    logic             anode_on;
    logic [3:0]       cur_dig;
    logic [6:0]       dec_seg;

    assign tick     = enable && (cnt == CNT_MAX);
    assign load_now = enable && (load_pend || (tick && (sel == 2'd3)));
    assign cur_dig  = shadow_dig[sel];
    assign anode_on = enable && (cnt >= GUARD_LIM) && !shadow_blank[sel];

    hex_to_seg7 u_decode (
        .hex   (cur_dig),
        .seg_n (dec_seg)
    );

    // Prescaler, slot select and snapshot; all frozen while enable is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            sel          <= 2'd0;
            shadow_dig   <= '0;
            shadow_blank <= 4'hF;
            shadow_dp    <= 4'h0;
            load_pend    <= 1'b1;
        end else if (enable) begin
            if (tick) begin
                cnt <= '0;
                sel <= sel + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (load_now) begin
                shadow_dig   <= {dig_3, dig_2, dig_1, dig_0};
                shadow_blank <= blank;
                shadow_dp    <= dp;
                load_pend    <= 1'b0;
            end
        end
    end

    // Registered output stage: reflects the slot state held during the previous cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_n       <= AN_OFF;
            seg_n      <= SEG_OFF;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an_n       <= anode_on ? ~(4'b0001 << sel) : AN_OFF;
            seg_n      <= dec_seg;
            dp_n       <= anode_on ? ~shadow_dp[sel] : 1'b1;
            frame_done <= tick && (sel == 2'd3);
        end
    end

endmodule

// File: tb/tb_seg7_disp_mux.sv
// Self-checking bench for seg7_disp_mux against a position-count reference model.
module tb_seg7_disp_mux;

    localparam int DIV   = 4;
    localparam int GUARD = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] dig_0, dig_1, dig_2, dig_3;
    logic [3:0] blank, dp;
    logic [3:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;
    logic       frame_done;

    always #5 clk = ~clk;

    seg7_disp_mux #(.REFRESH_DIV(DIV), .GUARD_CYC(GUARD)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .dig_0      (dig_0),
        .dig_1      (dig_1),
        .dig_2      (dig_2),
        .dig_3      (dig_3),
        .blank      (blank),
        .dp         (dp),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    logic [6:0] segTable [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model: mPos counts enabled cycles since reset; slot and phase follow from it.
    int         mPos = 0;
    bit         mLoaded = 1'b0;
    logic [3:0] mDig [4];
    logic [3:0] mBlank = 4'hF;
    logic [3:0] mDp = 4'h0;

    int cmpCount = 0;
    int errCount = 0;

    task automatic checkOutput(input string tag, input logic [6:0] got, input logic [6:0] want);
        cmpCount++;
        assert (got === want) else begin
            errCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [3:0] d0,
                                 input logic [3:0] d1, input logic [3:0] d2,
                                 input logic [3:0] d3, input logic [3:0] b, input logic [3:0] p);
        reset  = r;
        enable = e;
        dig_0  = d0;
        dig_1  = d1;
        dig_2  = d2;
        dig_3  = d3;
        blank  = b;
        dp     = p;
    endtask

    // One clock: predict outputs from the model state before the edge, advance it, then compare.
    task automatic step();
        logic [3:0] eAn;
        logic [6:0] eSeg;
        logic       eDp, eFd, on;
        int         slot, phase;
        @(posedge clk);
        if (reset) begin
            eAn = 4'hF; eSeg = 7'h7F; eDp = 1'b1; eFd = 1'b0;
            mPos = 0; mLoaded = 1'b0; mBlank = 4'hF; mDp = 4'h0;
            for (int i = 0; i < 4; i++) mDig[i] = 4'h0;
        end else begin
            slot  = (mPos / DIV) % 4;
            phase = mPos % DIV;
            on    = enable && (phase >= GUARD) && !mBlank[slot];
            eAn   = on ? ~(4'b0001 << slot) : 4'hF;
            eSeg  = segTable[mDig[slot]];
            eDp   = on ? ~mDp[slot] : 1'b1;
            eFd   = enable && (phase == DIV - 1) && (slot == 3);
            if (enable) begin
                if (!mLoaded || eFd) begin
                    mDig[0] = dig_0; mDig[1] = dig_1; mDig[2] = dig_2; mDig[3] = dig_3;
                    mBlank = blank; mDp = dp; mLoaded = 1'b1;
                end
                mPos++;
            end
        end
        #1;
        checkOutput("an_n", {3'b000, an_n}, {3'b000, eAn});
        checkOutput("seg_n", seg_n, eSeg);
        checkOutput("dp_n", {6'b0, dp_n}, {6'b0, eDp});
        checkOutput("frame_done", {6'b0, frame_done}, {6'b0, eFd});
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic waitSlot(input int s, input int ph);
        bit found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (((mPos / DIV) % 4) == s && (mPos % DIV) == ph) found = 1'b1;
            else step();
        end
        cmpCount++;
        assert (found) else begin
            errCount++;
            $error("[TB] FAIL wait_slot: observed timeout expected slot %0d phase %0d", s, ph);
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h0);
        runCycles(2);

        $display("[TB] counting pattern 4321");
        applyStimulus(1'b0, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h0);
        runCycles(40);

        $display("[TB] dig_0 change while slot 2 is shown");
        waitSlot(2, 1);
        dig_0 = 4'h8;
        runCycles(24);

        $display("[TB] enable pause in slot 1");
        waitSlot(1, 2);
        enable = 1'b0;
        runCycles(5);
        enable = 1'b1;
        runCycles(20);

        $display("[TB] blank slot 2, dp on slot 0");
        blank = 4'b0100;
        dp    = 4'b0001;
        runCycles(36);

        $display("[TB] mid-slot reset and decode sweep");
        waitSlot(2, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        blank = 4'h0;
        for (int v = 0; v < 16; v++) begin
            dig_0 = 4'(v);
            dig_1 = 4'($urandom);
            dig_2 = 4'($urandom);
            dig_3 = 4'($urandom);
            dp    = 4'($urandom);
            runCycles(16);
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                dig_0 = 4'($urandom); dig_1 = 4'($urandom);
                dig_2 = 4'($urandom); dig_3 = 4'($urandom);
                blank = 4'($urandom); dp    = 4'($urandom);
            end
            enable = ($urandom_range(0, 7) != 0);
            reset  = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
